// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand_stage
// Description : ID/EX pipeline register with ALU control decode, M/W operand
//               forwarding and SrcA/SrcB selection for the execute ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [1:0]                ALUOpD,
  input  logic [2:0]                funct3D,
  input  logic                      funct7b5D,
  input  logic                      op5D,
  input  logic [1:0]                ALUSrcAD,
  input  logic                      ALUSrcBD,
  input  logic                      RegWriteD,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  output logic [DATA_WIDTH-1:0]     SrcAE,
  output logic [DATA_WIDTH-1:0]     SrcBE,
  output logic [3:0]                ALUControlE,
  output logic [DATA_WIDTH-1:0]     WriteDataE,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      RegWriteE
);

  logic [3:0]                alu_control_d;

  logic [DATA_WIDTH-1:0]     rd1_q;
  logic [DATA_WIDTH-1:0]     rd2_q;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [3:0]                alu_control_q;
  logic [1:0]                alu_src_a_q;
  logic                      alu_src_b_q;
  logic                      reg_write_q;

  logic [DATA_WIDTH-1:0]     fwd_a;
  logic [DATA_WIDTH-1:0]     fwd_b;

  // Decode the ALU operation in the decode stage so the E stage only sees a register
  always_comb begin
    alu_control_d = 4'b0000;
    case (ALUOpD)
      2'b01: alu_control_d = 4'b0001;
      2'b10: begin
        case (funct3D)
          3'b000:  alu_control_d = (op5D & funct7b5D) ? 4'b0001 : 4'b0000;
          3'b001:  alu_control_d = 4'b0101;
          3'b010:  alu_control_d = 4'b1000;
          3'b011:  alu_control_d = 4'b1001;
          3'b100:  alu_control_d = 4'b0100;
          3'b101:  alu_control_d = funct7b5D ? 4'b0110 : 4'b0111;
          3'b110:  alu_control_d = 4'b0011;
          default: alu_control_d = 4'b0010;
        endcase
      end
      default: alu_control_d = 4'b0000;
    endcase
  end

  // E-stage registers: flush inserts a bubble and wins over stall, stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q         <= '0;
      rd2_q         <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_control_q <= 4'b0000;
      alu_src_a_q   <= 2'b00;
      alu_src_b_q   <= 1'b0;
      reg_write_q   <= 1'b0;
    end else if (FlushE) begin
      rd1_q         <= '0;
      rd2_q         <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_control_q <= 4'b0000;
      alu_src_a_q   <= 2'b00;
      alu_src_b_q   <= 1'b0;
      reg_write_q   <= 1'b0;
    end else if (!StallE) begin
      rd1_q         <= RD1D;
      rd2_q         <= RD2D;
      pc_q          <= PCD;
      imm_q         <= ImmExtD;
      rs1_q         <= Rs1D;
      rs2_q         <= Rs2D;
      rd_q          <= RdD;
      alu_control_q <= alu_control_d;
      alu_src_a_q   <= ALUSrcAD;
      alu_src_b_q   <= ALUSrcBD;
      reg_write_q   <= RegWriteD;
    end
  end

  // Forward the youngest in-flight result; x0 is hard-wired zero so never forwarded
  always_comb begin
    fwd_a = rd1_q;
    if (RegWriteM && (RdM != '0) && (RdM == rs1_q)) begin
      fwd_a = ALUResultM;
    end else if (RegWriteW && (RdW != '0) && (RdW == rs1_q)) begin
      fwd_a = ResultW;
    end
    fwd_b = rd2_q;
    if (RegWriteM && (RdM != '0) && (RdM == rs2_q)) begin
      fwd_b = ALUResultM;
    end else if (RegWriteW && (RdW != '0) && (RdW == rs2_q)) begin
      fwd_b = ResultW;
    end
  end

  // Operand A source: forwarded rs1, PC (auipc/jal), or zero (lui)
  always_comb begin
    case (alu_src_a_q)
      2'b00:   SrcAE = fwd_a;
      2'b01:   SrcAE = pc_q;
      default: SrcAE = '0;
    endcase
  end

  assign SrcBE       = alu_src_b_q ? imm_q : fwd_b;
  assign WriteDataE  = fwd_b;
  assign ALUControlE = alu_control_q;
  assign RdE         = rd_q;
  assign RegWriteE   = reg_write_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_operand_stage
// Description : Directed-vector scoreboard bench for id_ex_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallE, FlushE;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ALUOpD;
  logic [2:0]  funct3D;
  logic        funct7b5D, op5D;
  logic [1:0]  ALUSrcAD;
  logic        ALUSrcBD, RegWriteD;
  logic [4:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [31:0] ALUResultM, ResultW;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [3:0]  ALUControlE;
  logic [4:0]  RdE;
  logic        RegWriteE;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ac;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  id_ex_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUOpD(ALUOpD),
    .funct3D(funct3D), .funct7b5D(funct7b5D), .op5D(op5D),
    .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .RegWriteD(RegWriteD),
    .RdM(RdM), .RegWriteM(RegWriteM), .ALUResultM(ALUResultM),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultW(ResultW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
    .WriteDataE(WriteDataE), .RdE(RdE), .RegWriteE(RegWriteE)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, one expectation per cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "SrcAE",       SrcAE,               e.a);
      chk(e.name, "SrcBE",       SrcBE,               e.b);
      chk(e.name, "ALUControlE", {28'd0, ALUControlE}, {28'd0, e.ac});
      chk(e.name, "WriteDataE",  WriteDataE,          e.wd);
      chk(e.name, "RdE",         {27'd0, RdE},        {27'd0, e.rd});
      chk(e.name, "RegWriteE",   {31'd0, RegWriteE},  {31'd0, e.rw});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] ac, input logic [31:0] wd,
                      input logic [4:0] rd, input logic rw);
    exp_t e;
    e.name = name; e.a = a; e.b = b; e.ac = ac; e.wd = wd; e.rd = rd; e.rw = rw;
    q.push_back(e);
  endtask

  task automatic load(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                      input logic o5, input logic [1:0] sa, input logic sb,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic [31:0] pc, input logic [31:0] imm, input logic rw);
    ALUOpD = aluop; funct3D = f3; funct7b5D = f7; op5D = o5;
    ALUSrcAD = sa; ALUSrcBD = sb; Rs1D = rs1; Rs2D = rs2; RdD = rd;
    RD1D = rd1; RD2D = rd2; PCD = pc; ImmExtD = imm; RegWriteD = rw;
  endtask

  task automatic mw(input logic [4:0] rdm, input logic rwm, input logic [31:0] resm,
                    input logic [4:0] rdw, input logic rww, input logic [31:0] resw);
    RdM = rdm; RegWriteM = rwm; ALUResultM = resm;
    RdW = rdw; RegWriteW = rww; ResultW = resw;
  endtask

  logic [2:0] dec_f3 [7] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111, 3'b000};
  logic [3:0] dec_ac [7] = '{4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0011, 4'b0010, 4'b0000};

  initial begin
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    load(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0);
    mw(5'd0, 1'b0, 0, 5'd0, 1'b0, 0);
    tick();
    push("reset", 0, 0, 4'b0000, 0, 5'd0, 1'b0);
    tick();
    rst_n = 1'b1;

    // R-type sub
    load(2'b10, 3'b000, 1'b1, 1'b1, 2'b00, 1'b0, 5'd1, 5'd2, 5'd3, 32'd100, 32'd30, 32'h40, 32'h7, 1'b1);
    tick(); mw(5'd0, 1'b0, 0, 5'd0, 1'b0, 0);
    push("sub", 32'd100, 32'd30, 4'b0001, 32'd30, 5'd3, 1'b1);
    // addi with funct7b5 set must still add
    load(2'b10, 3'b000, 1'b1, 1'b0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd9, 0, 32'h10, 1'b1);
    tick();
    push("addi", 32'd5, 32'h10, 4'b0000, 32'd9, 5'd4, 1'b1);
    // sra / srl
    load(2'b10, 3'b101, 1'b1, 1'b1, 2'b00, 1'b0, 5'd1, 5'd2, 5'd5, 32'h8000_0000, 32'd4, 0, 0, 1'b1);
    tick();
    push("sra", 32'h8000_0000, 32'd4, 4'b0110, 32'd4, 5'd5, 1'b1);
    load(2'b10, 3'b101, 1'b0, 1'b1, 2'b00, 1'b0, 5'd1, 5'd2, 5'd5, 32'h8000_0000, 32'd4, 0, 0, 1'b1);
    tick();
    push("srl", 32'h8000_0000, 32'd4, 4'b0111, 32'd4, 5'd5, 1'b1);
    // branch compare (sub), no write
    load(2'b01, 3'b111, 1'b0, 1'b0, 2'b00, 1'b0, 5'd1, 5'd2, 5'd0, 32'd7, 32'd8, 0, 0, 1'b0);
    tick();
    push("beq_sub", 32'd7, 32'd8, 4'b0001, 32'd8, 5'd0, 1'b0);
    // ALUOp 11 decodes to add regardless of funct
    load(2'b11, 3'b101, 1'b1, 1'b1, 2'b00, 1'b0, 5'd1, 5'd2, 5'd6, 32'd3, 32'd4, 0, 0, 1'b1);
    tick();
    push("aluop11", 32'd3, 32'd4, 4'b0000, 32'd4, 5'd6, 1'b1);
    // remaining funct3 decodes
    for (int i = 0; i < 7; i++) begin
      load(2'b10, dec_f3[i], 1'b0, 1'b1, 2'b00, 1'b0, 5'd1, 5'd2, 5'd6, 32'h11, 32'h22, 0, 0, 1'b1);
      tick();
      push($sformatf("dec_f3_%0d", dec_f3[i]), 32'h11, 32'h22, dec_ac[i], 32'h22, 5'd6, 1'b1);
    end

    // forwarding: M beats W, then W alone, then independent A/B sources
    load(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 5'd5, 5'd6, 5'd13, 32'd1, 32'd2, 0, 0, 1'b1);
    tick(); mw(5'd5, 1'b1, 32'h1234, 5'd5, 1'b1, 32'hAAAA);
    push("fwd_m", 32'h1234, 32'd2, 4'b0000, 32'd2, 5'd13, 1'b1);
    tick(); mw(5'd5, 1'b0, 32'h1234, 5'd5, 1'b1, 32'hAAAA);
    push("fwd_w", 32'hAAAA, 32'd2, 4'b0000, 32'd2, 5'd13, 1'b1);
    tick(); mw(5'd6, 1'b1, 32'h5555, 5'd5, 1'b1, 32'hAAAA);
    push("fwd_ab", 32'hAAAA, 32'h5555, 4'b0000, 32'h5555, 5'd13, 1'b1);

    // x0 is never forwarded
    load(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd12, 0, 0, 0, 0, 1'b1);
    tick(); mw(5'd0, 1'b1, 32'hFFFF, 5'd0, 1'b1, 32'hEEEE);
    push("x0_nofwd", 0, 0, 4'b0000, 0, 5'd12, 1'b1);
    load(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 5'd0, 5'd12, 0, 0, 0, 32'h10, 1'b1);
    tick();
    push("x0_imm", 0, 32'h10, 4'b0000, 0, 5'd12, 1'b1);

    // flush beats stall on the same edge
    load(2'b10, 3'b111, 1'b0, 1'b1, 2'b01, 1'b1, 5'd1, 5'd2, 5'd7, 32'h5, 32'h6, 32'h20, 32'h30, 1'b1);
    StallE = 1'b1; FlushE = 1'b1;
    tick(); mw(5'd0, 1'b0, 0, 5'd0, 1'b0, 0);
    push("flush_stall", 0, 0, 4'b0000, 0, 5'd0, 1'b0);
    StallE = 1'b0; FlushE = 1'b0;

    // stall holds for three edges while forwarding still tracks M
    load(2'b10, 3'b010, 1'b0, 1'b1, 2'b00, 1'b0, 5'd7, 5'd8, 5'd9, 32'h77, 32'h88, 0, 0, 1'b1);
    tick();
    push("pre_stall", 32'h77, 32'h88, 4'b1000, 32'h88, 5'd9, 1'b1);
    load(2'b00, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1, 5'd1, 5'd2, 5'd2, 32'd1, 32'd2, 32'h4, 32'h8, 1'b0);
    StallE = 1'b1;
    tick();
    push("stall_1", 32'h77, 32'h88, 4'b1000, 32'h88, 5'd9, 1'b1);
    tick();
    push("stall_2", 32'h77, 32'h88, 4'b1000, 32'h88, 5'd9, 1'b1);
    tick(); mw(5'd7, 1'b1, 32'hBEEF, 5'd0, 1'b0, 0);
    push("stall_3_fwd", 32'hBEEF, 32'h88, 4'b1000, 32'h88, 5'd9, 1'b1);
    StallE = 1'b0;

    // lui: zero operand A even with a forwarding match
    load(2'b00, 3'b000, 1'b0, 1'b0, 2'b10, 1'b1, 5'd3, 5'd0, 5'd10, 32'h33, 0, 0, 32'h1234_5000, 1'b1);
    tick(); mw(5'd3, 1'b1, 32'h999, 5'd0, 1'b0, 0);
    push("lui", 0, 32'h1234_5000, 4'b0000, 0, 5'd10, 1'b1);
    // auipc: operand A is the PC
    load(2'b00, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1, 5'd0, 5'd0, 5'd11, 0, 0, 32'h80, 32'h1000, 1'b1);
    tick(); mw(5'd0, 1'b0, 0, 5'd0, 1'b0, 0);
    push("auipc", 32'h80, 32'h1000, 4'b0000, 0, 5'd11, 1'b1);

    // asynchronous reset mid-stall, observed before any further clock edge
    StallE = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    push("async_reset", 0, 0, 4'b0000, 0, 5'd0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
